// File: rtl/sevenseg_bcd_scan_driver_if.sv
// Load/convert handshake between an ALU result producer and the seven-segment scan driver.
// The producer side uses the master modport and the driver side uses the slave modport.
interface sevenseg_bcd_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic        done;

    modport master (output load, output value, input busy, input done);
    modport slave  (input load, input value, output busy, output done);
endinterface

// File: rtl/sevenseg_bcd_scan_driver.sv
// Sequential double-dabble BCD converter feeding a four-digit, active-low seven-segment scanner.
// The 1 kHz scan input is edge-detected in the clk domain and is never used as a clock.
module sevenseg_bcd_scan_driver #(
    parameter int          BLANK_LEADING = 1,
    parameter int unsigned OVF_LIMIT     = 9999
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_in,
    sevenseg_bcd_scan_driver_if.slave    bus,
    output logic [3:0]                   an,
    output logic [6:0]                   seg
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_next;
    logic [15:0] bin, bin_next;
    logic [19:0] bcd, bcd_next, bcd_adj;
    logic [3:0]  count, count_next;
    logic        ovf_pend, ovf_pend_next;
    logic        busy_q, busy_next;
    logic        done_q, done_next;
    logic [15:0] disp, disp_next;
    logic        ovf, ovf_next;

    logic        scan_q;
    logic        tick;
    logic [1:0]  index, index_next;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign tick       = scan_in & ~scan_q;
    assign index_next = index + 2'd1;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b1111111;
        endcase
    endfunction

    // A digit is blanked when it and every digit above it are zero; digit 0 is always shown.
    function automatic logic [6:0] digit_pattern(input logic [1:0] idx, input logic [15:0] digits,
                                                 input logic overflow);
        logic blank;
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (digits[15:4]  == 12'd0);
            2'd2:    blank = (digits[15:8]  == 8'd0);
            2'd3:    blank = (digits[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        if (overflow)
            digit_pattern = 7'b0111111;
        else if ((BLANK_LEADING != 0) && blank)
            digit_pattern = 7'b1111111;
        else
            digit_pattern = encode(digits[{idx, 2'b00} +: 4]);
    endfunction

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch forms.
        state_next    = state;
        bin_next      = bin;
        bcd_next      = bcd;
        count_next    = count;
        ovf_pend_next = ovf_pend;
        busy_next     = busy_q;
        done_next     = 1'b0;
        disp_next     = disp;
        ovf_next      = ovf;
        bcd_adj       = bcd;

        case (state)
            IDLE: begin
                if (bus.load) begin
                    bin_next      = bus.value;
                    bcd_next      = 20'd0;
                    count_next    = 4'd0;
                    ovf_pend_next = 32'(bus.value) > OVF_LIMIT;
                    busy_next     = 1'b1;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < 5; i++) begin
                    if (bcd[4*i +: 4] >= 4'd5)
                        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
                end
                {bcd_next, bin_next} = {bcd_adj[18:0], bin, 1'b0};
                count_next = count + 4'd1;
                if (count == 4'd15) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    disp_next  = bcd_next[15:0];
                    ovf_next   = ovf_pend;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bin      <= 16'd0;
            bcd      <= 20'd0;
            count    <= 4'd0;
            ovf_pend <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            disp     <= 16'd0;
            ovf      <= 1'b0;
            scan_q   <= 1'b0;
            index    <= 2'd0;
            an       <= 4'b1111;
            seg      <= 7'b1111111;
        end else begin
            state    <= state_next;
            bin      <= bin_next;
            bcd      <= bcd_next;
            count    <= count_next;
            ovf_pend <= ovf_pend_next;
            busy_q   <= busy_next;
            done_q   <= done_next;
            disp     <= disp_next;
            ovf      <= ovf_next;
            scan_q   <= scan_in;
            // seg only changes on a tick, and a same-edge commit is already visible through disp_next.
            if (tick) begin
                index <= index_next;
                an    <= ~(4'b0001 << index_next);
                seg   <= digit_pattern(index_next, disp_next, ovf_next);
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_bcd_scan_driver.sv
// Randomized scoreboard bench: two drivers (leading blanking on and off) share one stimulus stream.
// Expected digits come from decimal arithmetic on the committed value, not from BCD hardware.
module tb_sevenseg_bcd_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_in = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'd0;
    logic [3:0]  an1, an0;
    logic [6:0]  seg1, seg0;

    sevenseg_bcd_scan_driver_if bus1 ();
    sevenseg_bcd_scan_driver_if bus0 ();

    assign bus1.load  = load;
    assign bus1.value = value;
    assign bus0.load  = load;
    assign bus0.value = value;

    sevenseg_bcd_scan_driver #(.BLANK_LEADING(1), .OVF_LIMIT(9999)) dut_bl1 (
        .clk(clk), .rst(rst), .scan_in(scan_in), .bus(bus1), .an(an1), .seg(seg1));
    sevenseg_bcd_scan_driver #(.BLANK_LEADING(0), .OVF_LIMIT(9999)) dut_bl0 (
        .clk(clk), .rst(rst), .scan_in(scan_in), .bus(bus0), .an(an0), .seg(seg0));

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   cur_l = -1000;
    int   errors = 0;
    int   checks = 0;
    bit   scan_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input int v, input int idx, input bit blank_leading);
        int pow10[4];
        logic [6:0] pat[10];
        pow10 = '{1, 10, 100, 1000};
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 9999) return 7'b0111111;
        if (blank_leading && idx > 0 && v < pow10[idx]) return 7'b1111111;
        return pat[(v / pow10[idx]) % 10];
    endfunction

    // Reference display state, one entry per blanking variant (index 1 = blanking on).
    int       m_disp = 0;
    int       m_idx = 0;
    logic [3:0] m_an[2];
    logic [6:0] m_seg[2];
    bit       m_q = 1'b0;
    bit       last_scan = 1'b0;
    bit       prev_rst = 1'b1;
    bit       exp_busy;
    exp_t     e;

    always @(negedge clk) begin
        if (prev_rst || rst) begin
            m_disp = 0;
            m_idx  = 0;
            m_q    = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_an[k]  = 4'b1111;
                m_seg[k] = 7'b1111111;
            end
        end else begin
            if (bus1.done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    m_disp = e.val;
                end
            end
            if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                check("done_timeout", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (last_scan && !m_q) begin
                m_idx = (m_idx + 1) % 4;
                for (int k = 0; k < 2; k++) begin
                    m_an[k]  = ~(4'b0001 << m_idx);
                    m_seg[k] = model_seg(m_disp, m_idx, k == 1);
                end
            end
            m_q = last_scan;
        end
        exp_busy = (cyc >= cur_l) && (cyc <= cur_l + 15) && !rst;
        check("an_seg_bl1", {21'd0, an1, seg1}, {21'd0, m_an[1], m_seg[1]});
        check("an_seg_bl0", {21'd0, an0, seg0}, {21'd0, m_an[0], m_seg[0]});
        check("busy_bl1", {31'd0, bus1.busy}, {31'd0, exp_busy});
        check("busy_bl0", {31'd0, bus0.busy}, {31'd0, exp_busy});
        check("done_match", {31'd0, bus0.done}, {31'd0, bus1.done});
        last_scan = scan_in;
        prev_rst  = rst;
    end

    // Scan source: a shortened square wave with random half-periods, synchronous to clk.
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!scan_en) begin
                scan_in = 1'b0;
            end else if (hold <= 0) begin
                scan_in = ~scan_in;
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
        end
    end

    // A load is accepted only if its edge comes after the previous conversion has returned to IDLE.
    task automatic load_value(input int v);
        int l;
        @(posedge clk);
        #1;
        l = cyc + 1;
        if (l >= cur_l + 17) begin
            cur_l = l;
            sb.push_back('{v, l + 16});
        end
        load  = 1'b1;
        value = 16'(v);
        @(posedge clk);
        #1;
        load  = 1'b0;
        value = 16'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        cur_l = -1000;
        #1;
        check("rst_busy", {31'd0, bus1.busy}, 32'd0);
        check("rst_done", {31'd0, bus1.done}, 32'd0);
        check("rst_an_seg", {21'd0, an1, seg1}, {21'd0, 4'b1111, 7'b1111111});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int v;
        m_an  = '{4'b1111, 4'b1111};
        m_seg = '{7'b1111111, 7'b1111111};
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(30);

        load_value(1234);
        idle(20);
        scan_en = 1'b1;
        idle(60);
        load_value(7);
        idle(60);
        load_value(10000);
        idle(60);
        load_value(16'hFFFF);
        idle(60);
        load_value(42);
        idle(4);
        load_value(99);
        idle(60);

        load_value(12345);
        idle(7);
        do_reset();
        idle(5);
        load_value(0);
        idle(60);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 99);
                2:       v = $urandom_range(0, 9999);
                default: v = int'($urandom & 32'hFFFF);
            endcase
            load_value(v);
            idle($urandom_range(0, 25));
        end

        idle(40);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sevenseg_bcd_scan_driver.md
Name: sevenseg_bcd_scan_driver

Overview:
- Downstream consumer of the 100 MHz-to-1 kHz clock divider output.
- Takes a 16-bit unsigned ALU result on a load strobe and converts it to BCD with a sequential double-dabble engine (one bit per clk).
- Time-multiplexes four active-low seven-segment digits, advancing one digit per rising edge of the 1 kHz divider signal.
- The divider output is used as data (edge-detected in the clk domain), never as a clock.

Parameters:
- BLANK_LEADING, 1, when 1 blank leading zero digits (digit 0 always shown); when 0 show all four digits.
- OVF_LIMIT, 9999, largest value displayed numerically; larger values show "----".

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-high reset.
- scan_in  input  1  1 kHz square wave from the clk divider, synchronous to clk.
- load  input  1  one-cycle strobe; capture value and start conversion.
- value  input  16  unsigned binary value to display.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are committed.
- an  output  4  digit enables, active-low, an[0] = rightmost digit.
- seg  output  7  segments, active-low, {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, immediate), all values held while rst=1:
  - an=4'b1111, seg=7'b1111111, busy=0, done=0.
  - Digit index=0, scan_q=0, display register=0 (no overflow).
  - Any conversion in flight is aborted.
- Scan tick:
  - tick = scan_in & ~scan_q; scan_q registers scan_in every clk.
  - On a clk edge with tick=1: index <= index+1 (mod 4, wraps 3->0).
  - On that same edge, an and seg take the pattern for the new index.
  - Exactly one an bit is low after the first tick; all are high before it.
  - Latency: outputs change on the first clk edge that samples scan_in=1.
- Conversion FSM, states IDLE and SHIFT:
  - IDLE: on an edge sampling load=1, capture value into shift register, clear the 20-bit BCD accumulator, set busy<=1 and count<=0, go to SHIFT.
  - SHIFT: each edge, add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1 and increment count.
  - On the 16th SHIFT edge (L+16, where L is the load edge): busy<=0, done<=1, display register <= result, return to IDLE.
  - busy is high for exactly 16 cycles; done is high only during the cycle after L+16.
  - load while busy=1 is ignored; value is sampled only on the load edge.
- Overflow: if the captured value > OVF_LIMIT, the commit sets the overflow flag and all four digits show dash 7'b0111111.
- Digit encoding (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank=1111111.
- Leading blanking (BLANK_LEADING=1): digits above the most significant nonzero digit show blank, with their an still asserted in turn. Value 0 shows "0" on digit 0 only.
- Commit vs. scan:
  - A commit does not alter seg for the currently lit digit; new digits appear from the next tick.
  - A commit and a tick on the same edge: the tick uses the newly committed digits.
- load and tick are independent and may coincide.
- Reset mid-conversion returns to IDLE with busy=0 and no done pulse.

Test Plan:
- Reset released, scan_in held low -> an=1111, seg=1111111 indefinitely; busy=0, done=0.
- load with value=1234, then count cycles -> busy high exactly 16 cycles, done pulse once. Four subsequent ticks -> (an=1101, seg=0110000 "3"), (1011, 0100100 "2"), (0111, 1111001 "1"), (1110, 0011001 "4"); index wraps 3->0.
- value=7, BLANK_LEADING=1 -> digit 0 shows 1111000, digits 1-3 show 1111111. With BLANK_LEADING=0, digits 1-3 show 1000000.
- value=10000 and value=16'hFFFF -> after done, all digits show 0111111.
- load value=42, then a second load 5 cycles later with value=99 -> second load ignored; display shows 42; done pulses once.
- rst asserted at cycle 8 of a conversion -> busy=0 immediately, no done pulse. Next load of 0 -> single "0" on digit 0.
